serial_pattern_tx: RTL and testbench

//   Parallel-to-serial pattern transmitter. It is the source end of the 1-bit

---
 rtl/serial_pattern_tx.sv | 75 +++++++
 tb/tb_serial_pattern_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial transmitter: latches a WIDTH-bit word on start and shifts it
// out MSB-first with a valid qualifier and a one-cycle done pulse after the last bit.
module serial_pattern_tx #(
    parameter int   WIDTH    = 16,
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            // DONE behaves like IDLE for acceptance, giving a single gap cycle between words
            S_IDLE, S_DONE: begin
                if (start) begin
                    shreg_d = data_in;
                    cnt_d   = CW'(WIDTH);
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode from registered state only; x holds IDLE_LVL outside SHIFT.
    assign valid = (state_q == S_SHIFT);
    assign busy  = (state_q == S_SHIFT);
    assign done  = (state_q == S_DONE);
    assign ready = (state_q == S_IDLE) || (state_q == S_DONE);
    assign x     = (state_q == S_SHIFT) ? shreg_q[WIDTH-1] : IDLE_LVL;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: reset, single word, back-to-back,
// start-while-busy, mid-word reset and a loopback into a small "101" detector.
module tb_serial_pattern_tx;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] data_in;
    logic        ready, x, valid, busy, done;

    int checks   = 0;
    int failures = 0;

    serial_pattern_tx #(.WIDTH(16), .IDLE_LVL(1'b0)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .data_in (data_in),
        .ready   (ready),
        .x       (x),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overlapping "101" detector fed from the serial stream (Mealy output y)
    logic       det_clr;
    logic [1:0] hist;
    logic       y;
    always_ff @(posedge clk) begin
        if (det_clr)    hist <= 2'b00;
        else if (valid) hist <= {hist[0], x};
    end
    assign y = valid && (hist == 2'b10) && x;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, "_x"},     16'(x),     16'h0);
        chk({tag, "_valid"}, 16'(valid), 16'h0);
        chk({tag, "_busy"},  16'(busy),  16'h0);
        chk({tag, "_done"},  16'(done),  16'(exp_done));
        chk({tag, "_ready"}, 16'(ready), 16'h1);
    endtask

    // Expects the DUT to be showing bit 0 of w; leaves it on the cycle after the last bit.
    task automatic chk_word(input string tag, input logic [15:0] w);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s_bit%0d", tag, i), 16'(x), 16'(w[15-i]));
            chk($sformatf("%s_vld%0d", tag, i), 16'({valid, busy, ready}), 16'b110);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] y_exp;
        y_exp   = 16'h00AA;
        rst     = 1'b1;
        start   = 1'b1;
        data_in = 16'hFFFF;
        det_clr = 1'b1;

        // T1: reset held two edges with start high
        @(negedge clk);
        @(negedge clk);
        chk_idle("t1_rst", 1'b0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk_idle("t1_after", 1'b0);

        // T2: single word
        data_in = 16'b1000111010101010;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        data_in = 16'h0000;
        chk_word("t2", 16'b1000111010101010);
        chk_idle("t2_done", 1'b1);
        @(negedge clk);
        chk_idle("t2_idle", 1'b0);

        // T3: back-to-back with start held high
        data_in = 16'hFFFF;
        start   = 1'b1;
        @(negedge clk);
        data_in = 16'h0001;
        chk_word("t3a", 16'hFFFF);
        chk_idle("t3_gap", 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk_word("t3b", 16'h0001);
        chk_idle("t3_done", 1'b1);
        @(negedge clk);
        chk_idle("t3_idle", 1'b0);

        // T4: start with new data during bit 5 is ignored
        data_in = 16'hA5A5;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                start   = 1'b1;
                data_in = 16'h1234;
            end else if (i == 6) begin
                start = 1'b0;
            end
            chk($sformatf("t4_bit%0d", i), 16'(x), 16'(i < 8 ? (8'hA5 >> (7 - i)) & 8'h1 : (8'hA5 >> (15 - i)) & 8'h1));
            chk($sformatf("t4_vld%0d", i), 16'(valid), 16'h1);
            @(negedge clk);
        end
        chk_idle("t4_done", 1'b1);
        @(negedge clk);
        chk_idle("t4_idle", 1'b0);

        // T5: reset while bit 8 of F0F0 is on the line
        data_in = 16'hF0F0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t5_bit%0d", i), 16'(x), 16'(i < 4));
            @(negedge clk);
        end
        chk("t5_bit8_shown", 16'({valid, x}), 16'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("t5_abort", 1'b0);
        @(negedge clk);
        chk_idle("t5_nodone", 1'b0);

        // T6: loopback into the detector; new full word after the abort
        data_in = 16'b1000111010101010;
        start   = 1'b1;
        @(negedge clk);
        det_clr = 1'b0;
        start   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t6_bit%0d", i), 16'(x), 16'(((16'b1000111010101010) >> (15 - i)) & 16'h1));
            chk($sformatf("t6_y%0d", i), 16'(y), 16'(y_exp[15-i]));
            @(negedge clk);
        end
        chk_idle("t6_done", 1'b1);
        chk("t6_y_idle", 16'(y), 16'h0);
        @(negedge clk);
        chk_idle("t6_idle", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
